// File: rtl/adc_capture_packer.sv
// Pairs consecutive 16-bit ADC samples into 32-bit words for the upstream FIFO
// over a host-programmed window; drops words on FIFO full rather than stalling.
`timescale 1ns/1ps
module adc_capture_packer #(
    parameter int LEN_W  = 16,
    parameter int DROP_W = 8
) (
    input  logic              dco,
    input  logic              rst_n,
    input  logic [15:0]       cat_data,
    input  logic              capture_start,
    input  logic              capture_abort,
    input  logic [LEN_W-1:0]  capture_len,
    input  logic              fifo_full,
    output logic [31:0]       fifo_din,
    output logic              fifo_wr_en,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    state_e             state_q, state_d;
    logic               half_q, half_d;
    logic [15:0]        hold_lo_q, hold_lo_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [31:0]        fifo_din_q, fifo_din_d;
    logic               fifo_wr_en_q, fifo_wr_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic [DROP_W-1:0]  drop_q, drop_d;

    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        hold_lo_d    = hold_lo_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        fifo_din_d   = fifo_din_q;
        fifo_wr_en_d = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        drop_d       = drop_q;

        // Abort outranks everything, including a same-cycle start; drop stats survive it.
        if (capture_abort) begin
            state_d = S_IDLE;
            half_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (capture_start) begin
                        len_d      = capture_len;
                        cnt_d      = '0;
                        half_d     = 1'b0;
                        overflow_d = 1'b0;
                        drop_d     = '0;
                        if (capture_len == '0) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_CAPTURE;
                            busy_d  = 1'b1;
                            done_d  = 1'b0;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (!half_q) begin
                        hold_lo_d = cat_data;
                        half_d    = 1'b1;
                    end else begin
                        fifo_din_d   = {cat_data, hold_lo_q};
                        fifo_wr_en_d = !fifo_full;
                        if (fifo_full) begin
                            overflow_d = 1'b1;
                            if (drop_q != DROP_MAX)
                                drop_d = drop_q + DROP_ONE;
                        end
                        half_d = 1'b0;
                        // Dropped words still advance the count so the window length is fixed in time.
                        cnt_d  = cnt_q + LEN_ONE;
                        if (cnt_q == len_q - LEN_ONE) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    half_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge dco or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            half_q       <= 1'b0;
            hold_lo_q    <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            fifo_din_q   <= '0;
            fifo_wr_en_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            half_q       <= half_d;
            hold_lo_q    <= hold_lo_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            fifo_din_q   <= fifo_din_d;
            fifo_wr_en_q <= fifo_wr_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            drop_q       <= drop_d;
        end
    end

    assign fifo_din   = fifo_din_q;
    assign fifo_wr_en = fifo_wr_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule
